// File: rtl/shift_reg_if.sv
// Data-side bundle of the shift register: parallel load strobe/word in,
// register contents plus serial LSB and zero flag out.
interface shift_reg_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out;
  logic             shift_out;
  logic             empty;

  modport master (
    output load,
    output d_in,
    input  d_out,
    input  shift_out,
    input  empty
  );

  modport slave (
    input  load,
    input  d_in,
    output d_out,
    output shift_out,
    output empty
  );
endinterface

// File: rtl/shift_reg.sv
// Parallel-load, logical right-shift register with zero fill at the MSB.
// A controller loads a word, then drains it one bit per clock via shift_out.
module shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  shift_reg_if.slave  bus
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_next;

  assign w_shifted = {1'b0, r_data[WIDTH-1:1]};
  assign w_next    = bus.load ? bus.d_in : w_shifted;

  // There is no hold state: every non-load edge shifts, and zero is a fixed point.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
    end else begin
      r_data <= w_next;
    end
  end

  assign bus.d_out     = r_data;
  assign bus.shift_out = r_data[0];
  assign bus.empty     = (r_data == '0);

endmodule

// File: tb/tb_shift_reg.sv
// Scoreboard bench for shift_reg: stimulus queues hand-computed expectations,
// monitors compare after each rising edge or after an asynchronous reset event.
module tb_shift_reg;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] dOut;
    string            name;
  } expT;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  expT  edgeQ[$];
  expT  asyncQ[$];
  event asyncEv;

  shift_reg_if #(.WIDTH(WIDTH)) bus ();

  shift_reg #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic compareEntry(input expT e);
    logic expShift;
    logic expEmpty;
    expShift = e.dOut[0];
    expEmpty = (e.dOut == '0);
    checks++;
    if (bus.d_out !== e.dOut || bus.shift_out !== expShift || bus.empty !== expEmpty) begin
      errors++;
      $display("[TB] FAIL %s: got d_out=%h shift_out=%b empty=%b, expected d_out=%h shift_out=%b empty=%b",
               e.name, bus.d_out, bus.shift_out, bus.empty, e.dOut, expShift, expEmpty);
    end
  endtask

  // Edge monitor: each queued entry belongs to the next rising edge.
  always @(posedge clock) begin
    #1;
    if (edgeQ.size() > 0) compareEntry(edgeQ.pop_front());
  end

  always begin
    @(asyncEv);
    #1;
    while (asyncQ.size() > 0) compareEntry(asyncQ.pop_front());
  end

  // Drive inputs on the falling edge and queue the value expected after the next rising edge.
  task automatic applyStimulus(input logic ld, input logic [WIDTH-1:0] din,
                               input logic [WIDTH-1:0] expOut, input string name);
    expT e;
    @(negedge clock);
    bus.load = ld;
    bus.d_in = din;
    e.dOut   = expOut;
    e.name   = name;
    edgeQ.push_back(e);
  endtask

  task automatic checkOutput(input logic [WIDTH-1:0] expOut, input string name);
    expT e;
    e.dOut = expOut;
    e.name = name;
    asyncQ.push_back(e);
    -> asyncEv;
  endtask

  logic [WIDTH-1:0] drainExp [8];

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    bus.load = 1'b0;
    bus.d_in = '0;
    drainExp = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};

    #2;
    checkOutput(8'h00, "power-on reset");
    @(negedge clock);
    #2 reset = 1'b1;

    // Reset check: clear immediately, ignore load while held, stay zero after release.
    applyStimulus(1'b1, 8'hA5, 8'hA5, "load A5");
    @(negedge clock);
    bus.load = 1'b0;
    #1 reset = 1'b0;
    checkOutput(8'h00, "async reset clears A5");
    applyStimulus(1'b1, 8'hFF, 8'h00, "reset ignores load");
    applyStimulus(1'b0, 8'h00, 8'h00, "release edge 1");
    #2 reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, "release edge 2");

    applyStimulus(1'b1, 8'h55, 8'h55, "load 55");

    applyStimulus(1'b1, 8'hCC, 8'hCC, "load CC");
    applyStimulus(1'b0, 8'h00, 8'h66, "shift CC once");
    applyStimulus(1'b0, 8'h00, 8'h33, "shift CC twice");

    applyStimulus(1'b1, 8'hFF, 8'hFF, "load FF");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'hAA, drainExp[i], $sformatf("drain step %0d", i + 1));
    end
    applyStimulus(1'b0, 8'h00, 8'h00, "zero fixed point 1");
    applyStimulus(1'b0, 8'h00, 8'h00, "zero fixed point 2");

    applyStimulus(1'b1, 8'h11, 8'h11, "b2b load 11");
    applyStimulus(1'b1, 8'h22, 8'h22, "b2b load 22");
    applyStimulus(1'b1, 8'h81, 8'h81, "b2b load 81");
    applyStimulus(1'b0, 8'h00, 8'h40, "shift after b2b");

    // Mid-shift reset pulse between edges, then reload.
    applyStimulus(1'b1, 8'hF0, 8'hF0, "load F0");
    applyStimulus(1'b0, 8'h00, 8'h78, "shift F0 once");
    applyStimulus(1'b0, 8'h00, 8'h3C, "shift F0 twice");
    applyStimulus(1'b0, 8'h00, 8'h00, "edge after mid reset");
    #1 reset = 1'b0;
    checkOutput(8'h00, "mid-shift async reset");
    #2 reset = 1'b1;
    applyStimulus(1'b1, 8'h0F, 8'h0F, "reload 0F");
    applyStimulus(1'b0, 8'h00, 8'h07, "shift 0F once");

    for (int i = 0; i < 20 && edgeQ.size() > 0; i++) @(posedge clock);
    #3;
    if (edgeQ.size() > 0 || asyncQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain queue: %0d entries left, expected 0", edgeQ.size() + asyncQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
